vga_tile_framebuffer: RTL and testbench

// - Tile framebuffer directly upstream of the VGA timing/colour stage.
// - The processor writes one 3-bit RGB colour per 8x8-pixel tile, on an 80x60 grid.
// - The VGA stage presents its raw HCount/VCount once per pixel tick; this block returns that pixel's colour.
// - Also provides a hardware clear-screen engine that fills the whole grid with one colour.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/tile_ram_dp.sv | 35 +++
 rtl/vga_tile_framebuffer.sv | 141 ++++++++++++++
 tb/tb_vga_tile_framebuffer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, tile grid constants and clear FSM states
// Purpose: constants shared by the VGA timing stage and the tile framebuffer,
//          plus the tile-address helper used by both the read and write paths.
// Ports:   none (package).
package vga_pkg;

  localparam int HDAT_BEGIN = 143;
  localparam int VDAT_BEGIN = 34;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int COLS       = 80;
  localparam int ROWS       = 60;
  localparam int CELL_SHIFT = 3;
  localparam int RGB_W      = 3;
  localparam int ADDR_W     = 13;
  localparam int TILES      = COLS * ROWS;

  typedef enum logic [1:0] {
    C_IDLE,
    C_RUN,
    C_DONE
  } clr_state_e;

  // y*80 + x without a multiplier: y*64 + y*16 + x.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [6:0] x, input logic [5:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext = {7'd0, y};
    return (y_ext << 6) + (y_ext << 4) + {6'd0, x};
  endfunction

endpackage

// File: rtl/tile_ram_dp.sv
// rtl/tile_ram_dp.sv - simple dual-port tile RAM with registered read
// Purpose: one write port, one read port, read data registered when re is high.
//          Contents are not reset so the array maps onto block RAM.
// Ports:   clk; we/waddr/wdata write port; re/raddr read port; rdata registered output.
module tile_ram_dp #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/vga_tile_framebuffer.sv
// rtl/vga_tile_framebuffer.sv - 80x60 tile colour framebuffer with clear-screen engine
// Purpose: returns the colour of the pixel at (in_hcount, in_vcount) two pixel ticks
//          later, accepts single-tile writes via a req/ack handshake and can fill the
//          whole grid with one colour.
// Ports:   in_clock_50MHz, in_reset_n (async, active low); in_pix_tick, in_hcount,
//          in_vcount -> ou_pixel_rgb; in_wr_req/x/y/rgb -> ou_wr_ack, ou_wr_err;
//          in_clr_req (fill colour from in_wr_rgb) -> ou_busy, ou_clr_done.
module vga_tile_framebuffer
  import vga_pkg::*;
(
  input  logic             in_clock_50MHz,
  input  logic             in_reset_n,
  input  logic             in_pix_tick,
  input  logic [9:0]       in_hcount,
  input  logic [9:0]       in_vcount,
  output logic [RGB_W-1:0] ou_pixel_rgb,
  input  logic             in_wr_req,
  input  logic [6:0]       in_wr_x,
  input  logic [5:0]       in_wr_y,
  input  logic [RGB_W-1:0] in_wr_rgb,
  output logic             ou_wr_ack,
  output logic             ou_wr_err,
  input  logic             in_clr_req,
  output logic             ou_busy,
  output logic             ou_clr_done
);

  logic              act1_q, act1_d;
  logic              act2_q, act2_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [RGB_W-1:0]  fill_q, fill_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic [9:0]        hoff, voff;
  logic              h_act, v_act;
  logic              wr_oob, wr_fire;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [RGB_W-1:0]  ram_wdata;
  logic [RGB_W-1:0]  rd_data;

  // Read pipeline: stage 1 registers active flag and tile address, the RAM's
  // own read register is stage 2; active is delayed alongside to blank the data.
  always_comb begin
    hoff    = in_hcount - 10'(HDAT_BEGIN);
    voff    = in_vcount - 10'(VDAT_BEGIN);
    h_act   = (in_hcount >= 10'(HDAT_BEGIN)) && (in_hcount < 10'(HDAT_BEGIN + H_ACTIVE));
    v_act   = (in_vcount >= 10'(VDAT_BEGIN)) && (in_vcount < 10'(VDAT_BEGIN + V_ACTIVE));
    act1_d  = act1_q;
    act2_d  = act2_q;
    raddr_d = raddr_q;
    if (in_pix_tick) begin
      act1_d  = h_act && v_act;
      raddr_d = tile_addr(7'(hoff >> CELL_SHIFT), 6'(voff >> CELL_SHIFT));
      act2_d  = act1_q;
    end
  end

  // Write handshake and clear FSM share the single RAM write port; the clear
  // owns it while running, so processor writes are only accepted in C_IDLE.
  // Gating on ack_q keeps a req still held on the ack cycle from firing twice.
  always_comb begin
    wr_oob     = (in_wr_x >= 7'(COLS)) || (in_wr_y >= 6'(ROWS));
    wr_fire    = (state_q == C_IDLE) && in_wr_req && !in_clr_req && !ack_q;
    ack_d      = wr_fire;
    err_d      = wr_fire && wr_oob;
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    fill_d     = fill_q;
    case (state_q)
      C_IDLE: begin
        if (in_clr_req) begin
          fill_d     = in_wr_rgb;
          clr_addr_d = '0;
          state_d    = C_RUN;
        end
      end
      C_RUN: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == ADDR_W'(TILES - 1)) state_d = C_DONE;
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
    if (state_q == C_RUN) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr_q;
      ram_wdata = fill_q;
    end else begin
      ram_we    = wr_fire && !wr_oob;
      ram_waddr = tile_addr(in_wr_x, in_wr_y);
      ram_wdata = in_wr_rgb;
    end
  end

  always_ff @(posedge in_clock_50MHz or negedge in_reset_n) begin
    if (!in_reset_n) begin
      act1_q     <= 1'b0;
      act2_q     <= 1'b0;
      raddr_q    <= '0;
      state_q    <= C_IDLE;
      clr_addr_q <= '0;
      fill_q     <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      act1_q     <= act1_d;
      act2_q     <= act2_d;
      raddr_q    <= raddr_d;
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      fill_q     <= fill_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  tile_ram_dp #(
    .DEPTH(TILES),
    .AW   (ADDR_W),
    .DW   (RGB_W)
  ) u_ram (
    .clk  (in_clock_50MHz),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (in_pix_tick),
    .raddr(raddr_q),
    .rdata(rd_data)
  );

  assign ou_pixel_rgb = act2_q ? rd_data : '0;
  assign ou_wr_ack    = ack_q;
  assign ou_wr_err    = err_q;
  assign ou_busy      = (state_q == C_RUN);
  assign ou_clr_done  = (state_q == C_DONE);

endmodule

// File: tb/tb_vga_tile_framebuffer.sv
// tb/tb_vga_tile_framebuffer.sv - self-checking bench for vga_tile_framebuffer
module tb_vga_tile_framebuffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [9:0] hcount, vcount;
  logic [2:0] pixel_rgb;
  logic       wr_req;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [2:0] wr_rgb;
  logic       wr_ack, wr_err;
  logic       clr_req;
  logic       busy, clr_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         h;
    int         v;
    logic [2:0] e;
  } pt_t;

  pt_t        pts[$];
  logic [2:0] exp_q[$];

  always #10 clk = ~clk;

  vga_tile_framebuffer dut (
    .in_clock_50MHz(clk),
    .in_reset_n    (rst_n),
    .in_pix_tick   (tick),
    .in_hcount     (hcount),
    .in_vcount     (vcount),
    .ou_pixel_rgb  (pixel_rgb),
    .in_wr_req     (wr_req),
    .in_wr_x       (wr_x),
    .in_wr_y       (wr_y),
    .in_wr_rgb     (wr_rgb),
    .ou_wr_ack     (wr_ack),
    .ou_wr_err     (wr_err),
    .in_clr_req    (clr_req),
    .ou_busy       (busy),
    .ou_clr_done   (clr_done)
  );

  // One pixel tick: push the expected colour, then pop the entry whose output
  // is due now (coordinates presented one tick earlier).
  task automatic pix(input int h, input int v, input logic [2:0] e,
                     output bit have, output logic [2:0] got, output logic [2:0] want);
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    tick   = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    got  = pixel_rgb;
    want = '0;
    have = 1'b0;
    if (exp_q.size() > 1) begin
      want = exp_q.pop_front();
      have = 1'b1;
    end
  endtask

  task automatic do_write(input int x, input int y, input logic [2:0] rgb,
                          output int lat, output logic err);
    @(negedge clk);
    wr_req = 1'b1;
    wr_x   = 7'(x);
    wr_y   = 6'(y);
    wr_rgb = rgb;
    lat    = 0;
    err    = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (wr_ack) begin
        err = wr_err;
        break;
      end
    end
    wr_req = 1'b0;
  endtask

  task automatic run_clear(input logic [2:0] rgb, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    clr_req  = 1'b1;
    wr_rgb   = rgb;
    busy_cnt = 0;
    done_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (done_cnt != 0 && !busy && !clr_done) break;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic scan_pts(input string name);
    bit         have;
    logic [2:0] got, want;
    exp_q.delete();
    pts.push_back('{0, 0, 3'd0});
    foreach (pts[i]) begin
      pix(pts[i].h, pts[i].v, pts[i].e, have, got, want);
      if (have) begin
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s pixel (%0d,%0d) got %0d want %0d", name,
                   pts[i-1].h, pts[i-1].v, got, want);
        end
      end
    end
    pts.delete();
  endtask

  task automatic test_reset();
    bit         have;
    logic [2:0] got, want;
    rst_n = 1'b0; tick = 1'b0; hcount = '0; vcount = '0;
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0; clr_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pixel_rgb, wr_ack, wr_err, busy, clr_done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000000", {pixel_rgb, wr_ack, wr_err, busy, clr_done});
    end
    rst_n = 1'b1;
    exp_q.delete();
    pix(143, 34, 3'd0, have, got, want);
    checks++;
    if (got !== 3'd0) begin
      errors++;
      $display("FAIL reset_first_tick got %0d want 0", got);
    end
  endtask

  task automatic test_write();
    int   lat;
    logic err;
    do_write(0, 0, 3'd5, lat, err);
    checks++;
    if (lat !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write00 got lat=%0d err=%b want lat=1 err=0", lat, err);
    end
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_pulse got %b want 0", wr_ack);
    end
    do_write(79, 59, 3'd3, lat, err);
    checks++;
    if (lat !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write7959 got lat=%0d err=%b want lat=1 err=0", lat, err);
    end
    pts.push_back('{143, 34, 3'd5});
    pts.push_back('{150, 41, 3'd5});
    for (int k = 0; k < 8; k++) begin
      pts.push_back('{775 + k, 506, 3'd3});
      pts.push_back('{782, 506 + k, 3'd3});
    end
    pts.push_back('{783, 506, 3'd0});
    pts.push_back('{775, 514, 3'd0});
    pts.push_back('{142, 34, 3'd0});
    scan_pts("write");
  endtask

  task automatic test_write_err();
    int   lat;
    logic err;
    do_write(80, 0, 3'd7, lat, err);
    checks++;
    if (lat !== 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_x80 got lat=%0d err=%b want lat=1 err=1", lat, err);
    end
    do_write(0, 60, 3'd7, lat, err);
    checks++;
    if (lat !== 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_y60 got lat=%0d err=%b want lat=1 err=1", lat, err);
    end
    pts.push_back('{143, 34, 3'd5});
    pts.push_back('{782, 513, 3'd3});
    scan_pts("write_err");
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt;
    run_clear(3'd6, busy_cnt, done_cnt);
    checks++;
    if (busy_cnt !== 4800 || done_cnt !== 1) begin
      errors++;
      $display("FAIL clear6 got busy=%0d done=%0d want busy=4800 done=1", busy_cnt, done_cnt);
    end
    pts.push_back('{143, 34, 3'd6});
    pts.push_back('{782, 513, 3'd6});
    pts.push_back('{782, 34, 3'd6});
    pts.push_back('{143, 513, 3'd6});
    for (int k = 0; k < 30; k++)
      pts.push_back('{int'($urandom_range(782, 143)), int'($urandom_range(513, 34)), 3'd6});
    pts.push_back('{100, 200, 3'd0});
    pts.push_back('{400, 20, 3'd0});
    scan_pts("clear");
  endtask

  task automatic test_clear_write_collision();
    int busy_cnt = 0;
    int done_cnt = 0;
    int ack_cnt  = 0;
    int ack_busy = 0;
    @(negedge clk);
    clr_req = 1'b1; wr_req = 1'b1; wr_x = 7'd10; wr_y = 6'd5; wr_rgb = 3'd1;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    wr_rgb  = 3'd4;
    for (int i = 0; i < 6000; i++) begin
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (wr_ack) begin
        ack_cnt++;
        if (done_cnt == 0) ack_busy++;
        wr_req = 1'b0;
      end
      if (ack_cnt != 0) break;
      @(posedge clk);
      @(negedge clk);
    end
    wr_req = 1'b0;
    checks++;
    if (busy_cnt !== 4800 || done_cnt !== 1 || ack_cnt !== 1 || ack_busy !== 0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL collision got busy=%0d done=%0d ack=%0d early_ack=%0d err=%b want 4800 1 1 0 0",
               busy_cnt, done_cnt, ack_cnt, ack_busy, wr_err);
    end
    pts.push_back('{223, 74, 3'd4});
    pts.push_back('{230, 81, 3'd4});
    pts.push_back('{231, 74, 3'd1});
    pts.push_back('{143, 34, 3'd1});
    scan_pts("collision");
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt, done_cnt;
    int bad = 0;
    @(negedge clk);
    clr_req = 1'b1;
    wr_rgb  = 3'd7;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear got busy=%b done=%b want 0 0", busy, clr_done);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || clr_done !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || clr_done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d busy/done cycles want 0", bad);
    end
    run_clear(3'd2, busy_cnt, done_cnt);
    checks++;
    if (busy_cnt !== 4800 || done_cnt !== 1) begin
      errors++;
      $display("FAIL clear2 got busy=%0d done=%0d want busy=4800 done=1", busy_cnt, done_cnt);
    end
    pts.push_back('{143, 34, 3'd2});
    pts.push_back('{782, 513, 3'd2});
    pts.push_back('{460, 270, 3'd2});
    scan_pts("reset_mid_clear");
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_err();
    test_clear();
    test_clear_write_collision();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
